// File: rtl/mpadd_seq.sv
// Multi-precision add/subtract sequencer: one SIZE-bit adder shared across LIMBS limbs.
// Define MPADD_PIPE_ACCEPT_EN to allow a retire and a new accept on the same edge.
module mpadd_seq #(
    parameter int SIZE  = 4,
    parameter int LIMBS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SIZE*LIMBS-1:0] a,
    input  logic [SIZE*LIMBS-1:0] b,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SIZE*LIMBS-1:0] result,
    output logic                  cout,
    output logic                  ovf,
    output logic                  zero
);
    localparam int W  = SIZE * LIMBS;
    localparam int IW = (LIMBS > 1) ? $clog2(LIMBS) : 1;
    localparam logic [IW-1:0] LAST = IW'(LIMBS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            sub_q;
    logic            c;
    logic [IW-1:0]   i;

    logic [SIZE-1:0] a_limb;
    logic [SIZE-1:0] b_limb;
    logic [SIZE-1:0] s;
    logic            co;
    logic [W-1:0]    res_next;
    logic            accept;

    // Shared limb adder; res_next is the result with the current limb merged in,
    // so the flags registered on the last limb see the complete value.
    always_comb begin
        a_limb   = a_q[int'(i)*SIZE +: SIZE];
        b_limb   = b_q[int'(i)*SIZE +: SIZE] ^ {SIZE{sub_q}};
        {co, s}  = {1'b0, a_limb} + {1'b0, b_limb} + {{SIZE{1'b0}}, c};
        res_next = result;
        res_next[int'(i)*SIZE +: SIZE] = s;
    end

`ifdef MPADD_PIPE_ACCEPT_EN
    assign in_ready = ~rst & ((state == IDLE) | ((state == DONE) & out_ready));
`else
    assign in_ready = ~rst & (state == IDLE);
`endif

    assign accept    = in_valid & in_ready;
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
            c      <= 1'b0;
            i      <= '0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            sub_q <= sub;
            c     <= sub;
            i     <= '0;
            state <= RUN;
        end else begin
            case (state)
                RUN: begin
                    result <= res_next;
                    c      <= co;
                    if (i == LAST) begin
                        state <= DONE;
                        cout  <= co;
                        ovf   <= (a_q[W-1] ~^ (b_q[W-1] ^ sub_q)) & (res_next[W-1] ^ a_q[W-1]);
                        zero  <= (res_next == '0);
                    end else begin
                        i <= i + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mpadd_seq.sv
// Directed self-checking bench for mpadd_seq with SIZE=4, LIMBS=4.
module tb_mpadd_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        cout;
    logic        ovf;
    logic        zero;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    mpadd_seq #(.SIZE(4), .LIMBS(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    // Accepts one operation, waits for out_valid, captures outputs, retires it.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts,
                          output logic [15:0] r, output logic rc, output logic ro,
                          output logic rz, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk_cnt++;
        if (in_ready !== 1'b1) $display("FAIL run_op_ready: in_ready=%b required 1", in_ready);
        else pass_cnt++;
        a = ta; b = tb_v; sub = ts; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        r = result; rc = cout; ro = ovf; rz = zero;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk_cnt++;
        if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b required 0", in_ready);
        else pass_cnt++;
        chk_cnt++;
        if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b required 0", out_valid);
        else pass_cnt++;
        chk_cnt++;
        if ({result, cout, ovf, zero} !== 19'h0)
            $display("FAIL rst_outputs: got %h/%b%b%b required 0000/000", result, cout, ovf, zero);
        else pass_cnt++;
        rst = 1'b0;
        @(posedge clk); #1;
        chk_cnt++;
        if (in_ready !== 1'b1) $display("FAIL rst_release_ready: got %b required 1", in_ready);
        else pass_cnt++;
    endtask

    task automatic test_arith();
        logic [15:0] ta[5]; logic [15:0] tb_v[5]; logic ts[5];
        logic [15:0] er[5]; logic [2:0] ef[5];
        logic [15:0] r; logic rc, ro, rz; int lat;
        ta[0] = 16'h00FF; tb_v[0] = 16'h0001; ts[0] = 0; er[0] = 16'h0100; ef[0] = 3'b000;
        ta[1] = 16'hFFFF; tb_v[1] = 16'h0001; ts[1] = 0; er[1] = 16'h0000; ef[1] = 3'b101;
        ta[2] = 16'h7FFF; tb_v[2] = 16'h0001; ts[2] = 0; er[2] = 16'h8000; ef[2] = 3'b010;
        ta[3] = 16'h8000; tb_v[3] = 16'h0001; ts[3] = 1; er[3] = 16'h7FFF; ef[3] = 3'b110;
        ta[4] = 16'h0000; tb_v[4] = 16'h0001; ts[4] = 1; er[4] = 16'hFFFF; ef[4] = 3'b000;
        for (int k = 0; k < 5; k++) begin
            run_op(ta[k], tb_v[k], ts[k], r, rc, ro, rz, lat);
            chk_cnt++;
            if (r !== er[k]) $display("FAIL arith%0d_result: got %h required %h", k, r, er[k]);
            else pass_cnt++;
            chk_cnt++;
            if ({rc, ro, rz} !== ef[k])
                $display("FAIL arith%0d_flags(cout,ovf,zero): got %b required %b", k, {rc, ro, rz}, ef[k]);
            else pass_cnt++;
            chk_cnt++;
            if (lat !== 4) $display("FAIL arith%0d_latency: got %0d required 4", k, lat);
            else pass_cnt++;
            chk_cnt++;
            if (out_valid !== 1'b0) $display("FAIL arith%0d_retire: out_valid=%b required 0", k, out_valid);
            else pass_cnt++;
        end
    endtask

    task automatic test_hold();
        int n;
        a = 16'h1111; b = 16'h2222; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        a = 16'hAAAA; b = 16'h5555; sub = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk_cnt++;
            if (out_valid !== 1'b1) $display("FAIL hold%0d_out_valid: got %b required 1", k, out_valid);
            else pass_cnt++;
            chk_cnt++;
            if ({result, cout, ovf, zero} !== {16'h3333, 3'b000})
                $display("FAIL hold%0d_outputs: got %h/%b%b%b required 3333/000", k, result, cout, ovf, zero);
            else pass_cnt++;
            chk_cnt++;
            if (in_ready !== 1'b0) $display("FAIL hold%0d_in_ready: got %b required 0", k, in_ready);
            else pass_cnt++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk_cnt++;
        if (out_valid !== 1'b0) $display("FAIL hold_release: out_valid=%b required 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] r; logic rc, ro, rz; int lat;
        a = 16'hAAAA; b = 16'h1111; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk_cnt++;
        if (in_ready !== 1'b0) $display("FAIL midrst_in_ready_high: got %b required 0", in_ready);
        else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk_cnt++;
        if ({out_valid, result, cout, ovf, zero} !== 20'h0)
            $display("FAIL midrst_outputs: got %b/%h/%b%b%b required 0/0000/000", out_valid, result, cout, ovf, zero);
        else pass_cnt++;
        chk_cnt++;
        if (in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b required 1", in_ready);
        else pass_cnt++;
        repeat (5) begin @(posedge clk); #1; end
        chk_cnt++;
        if (out_valid !== 1'b0) $display("FAIL midrst_no_result: out_valid=%b required 0", out_valid);
        else pass_cnt++;
        run_op(16'h1234, 16'h1111, 1'b0, r, rc, ro, rz, lat);
        chk_cnt++;
        if (r !== 16'h2345) $display("FAIL midrst_next_result: got %h required 2345", r);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int cyc, nacc, nres, acc0, acc1, exp_gap;
        logic [15:0] res[2];
`ifdef MPADD_PIPE_ACCEPT_EN
        exp_gap = 5;
`else
        exp_gap = 6;
`endif
        cyc = 0; nacc = 0; nres = 0; acc0 = 0; acc1 = 0;
        res[0] = '0; res[1] = '0;
        a = 16'h0102; b = 16'h0304; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        while (nres < 2 && cyc < 40) begin
            if (out_valid) begin
                res[nres] = result;
                nres++;
            end
            if (nres == 2) in_valid = 1'b0;
            if (in_valid && in_ready) begin
                if (nacc == 0) acc0 = cyc; else acc1 = cyc;
                nacc++;
            end
            @(posedge clk); #1;
            cyc++;
            if (nacc == 1) begin a = 16'h1000; b = 16'h0001; sub = 1'b1; end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk_cnt++;
        if (nres !== 2) $display("FAIL b2b_result_count: got %0d required 2", nres);
        else pass_cnt++;
        chk_cnt++;
        if (acc1 - acc0 !== exp_gap) $display("FAIL b2b_accept_gap: got %0d required %0d", acc1 - acc0, exp_gap);
        else pass_cnt++;
        chk_cnt++;
        if (res[0] !== 16'h0406) $display("FAIL b2b_result0: got %h required 0406", res[0]);
        else pass_cnt++;
        chk_cnt++;
        if (res[1] !== 16'h0FFF) $display("FAIL b2b_result1: got %h required 0fff", res[1]);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_arith();
        test_hold();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
